gbt_rx_frame_checker: RTL and testbench

Frame-level integrity checker sitting directly downstream of the GBT transceiver bank, in the 40 MHz RX frame-clock domain. Consumes each received 84-bit GBT word, validates checksum and sequence continuity, and runs a lock state machine. Forwards only verified 64-bit motor payloads to the readout logic, and keeps saturating error statistics for diagnostics.

---
 rtl/gbt_rx_frame_checker.sv | 214 +++++++++++++++++++++
 tb/tb_gbt_rx_frame_checker.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbt_rx_frame_checker.sv
// GBT RX frame checker: checksum/sequence validation, lock FSM, payload forwarding one cycle after input, no backpressure.
// Statistic counters are built only when GBT_RX_CHECKER_STATS_EN is defined; otherwise they read 0.
module gbt_rx_frame_checker #(
    parameter int LOCK_GOOD      = 4,
    parameter int UNLOCK_BAD     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [83:0] rx_data_ib84,
    input  logic        rx_isdata_i,
    input  logic        rx_ready_i,
    input  logic        clear_stats_i,
    output logic [63:0] payload_ob64,
    output logic [3:0]  frame_type_ob4,
    output logic        payload_valid_o,
    output logic        locked_o,
    output logic [15:0] seq_err_cnt_ob16,
    output logic [15:0] chk_err_cnt_ob16,
    output logic [15:0] lost_lock_cnt_ob16
);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_SYNCING, ST_LOCKED} state_t;

    localparam logic [7:0]  LOCK_GOOD_W  = 8'(LOCK_GOOD);
    localparam logic [7:0]  UNLOCK_BAD_W = 8'(UNLOCK_BAD);
    localparam logic [15:0] TIMEOUT_W    = 16'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic [7:0]  exp_seq_q;
    logic [7:0]  good_cnt_q;
    logic [7:0]  bad_cnt_q;
    logic [15:0] idle_cnt_q;

    logic [7:0]  seq_w;
    logic [3:0]  type_w;
    logic [7:0]  chk_w;
    logic [63:0] payload_w;
    logic [7:0]  chk_calc_w;
    logic        examined_w;
    logic        chk_ok_w;
    logic        seq_ok_w;
    logic        good_w;
    logic [7:0]  good_inc_w;
    logic [7:0]  bad_inc_w;
    logic [15:0] idle_inc_w;
    logic        lose_lock_w;

    assign seq_w      = rx_data_ib84[83:76];
    assign type_w     = rx_data_ib84[75:72];
    assign chk_w      = rx_data_ib84[71:64];
    assign payload_w  = rx_data_ib84[63:0];

    always_comb begin
        chk_calc_w = '0;
        for (int i = 0; i < 8; i++) begin
            chk_calc_w = chk_calc_w ^ payload_w[8*i +: 8];
        end
    end

    assign examined_w = rx_ready_i & rx_isdata_i;
    assign chk_ok_w   = (chk_w == chk_calc_w);
    assign seq_ok_w   = (seq_w == exp_seq_q);
    assign good_w     = chk_ok_w & seq_ok_w;
    assign good_inc_w = good_cnt_q + 8'd1;
    assign bad_inc_w  = bad_cnt_q + 8'd1;
    assign idle_inc_w = idle_cnt_q + 16'd1;

    // Every way out of LOCKED: link drop, too many bad frames, or idle timeout.
    assign lose_lock_w = (state_q == ST_LOCKED) &&
                         (!rx_ready_i ||
                          (rx_isdata_i && !good_w && bad_inc_w == UNLOCK_BAD_W) ||
                          (!rx_isdata_i && idle_inc_w == TIMEOUT_W));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= ST_UNLOCKED;
            exp_seq_q       <= '0;
            good_cnt_q      <= '0;
            bad_cnt_q       <= '0;
            idle_cnt_q      <= '0;
            payload_ob64    <= '0;
            frame_type_ob4  <= '0;
            payload_valid_o <= 1'b0;
            locked_o        <= 1'b0;
        end else begin
            payload_valid_o <= 1'b0;
            if (!rx_ready_i) begin
                state_q    <= ST_UNLOCKED;
                exp_seq_q  <= '0;
                good_cnt_q <= '0;
                bad_cnt_q  <= '0;
                idle_cnt_q <= '0;
                locked_o   <= 1'b0;
            end else if (rx_isdata_i) begin
                idle_cnt_q <= '0;
                // A checksum-clean frame is trusted to resynchronise the sequence.
                exp_seq_q  <= chk_ok_w ? seq_w + 8'd1 : exp_seq_q + 8'd1;
                case (state_q)
                    ST_UNLOCKED: begin
                        if (chk_ok_w) begin
                            good_cnt_q <= 8'd1;
                            bad_cnt_q  <= '0;
                            if (LOCK_GOOD == 1) begin
                                state_q         <= ST_LOCKED;
                                locked_o        <= 1'b1;
                                payload_ob64    <= payload_w;
                                frame_type_ob4  <= type_w;
                                payload_valid_o <= 1'b1;
                            end else begin
                                state_q <= ST_SYNCING;
                            end
                        end
                    end
                    ST_SYNCING: begin
                        if (good_w) begin
                            good_cnt_q <= good_inc_w;
                            if (good_inc_w == LOCK_GOOD_W) begin
                                state_q         <= ST_LOCKED;
                                bad_cnt_q       <= '0;
                                locked_o        <= 1'b1;
                                payload_ob64    <= payload_w;
                                frame_type_ob4  <= type_w;
                                payload_valid_o <= 1'b1;
                            end
                        end else begin
                            state_q    <= ST_UNLOCKED;
                            good_cnt_q <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (good_w) begin
                            bad_cnt_q       <= '0;
                            payload_ob64    <= payload_w;
                            frame_type_ob4  <= type_w;
                            payload_valid_o <= 1'b1;
                        end else if (bad_inc_w == UNLOCK_BAD_W) begin
                            state_q    <= ST_UNLOCKED;
                            bad_cnt_q  <= '0;
                            good_cnt_q <= '0;
                            locked_o   <= 1'b0;
                        end else begin
                            bad_cnt_q <= bad_inc_w;
                        end
                    end
                    default: begin
                        state_q  <= ST_UNLOCKED;
                        locked_o <= 1'b0;
                    end
                endcase
            end else if (state_q == ST_LOCKED) begin
                if (idle_inc_w == TIMEOUT_W) begin
                    state_q    <= ST_UNLOCKED;
                    idle_cnt_q <= '0;
                    good_cnt_q <= '0;
                    bad_cnt_q  <= '0;
                    locked_o   <= 1'b0;
                end else begin
                    idle_cnt_q <= idle_inc_w;
                end
            end
        end
    end

`ifdef GBT_RX_CHECKER_STATS_EN
    logic [15:0] seq_err_q, seq_err_d;
    logic [15:0] chk_err_q, chk_err_d;
    logic [15:0] lost_lock_q, lost_lock_d;
    logic        seq_err_inc_w;
    logic        chk_err_inc_w;

    assign seq_err_inc_w = examined_w && chk_ok_w && !seq_ok_w && (state_q != ST_UNLOCKED);
    assign chk_err_inc_w = examined_w && !chk_ok_w;

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        seq_err_d   = seq_err_q;
        chk_err_d   = chk_err_q;
        lost_lock_d = lost_lock_q;
        if (clear_stats_i) begin
            seq_err_d   = '0;
            chk_err_d   = '0;
            lost_lock_d = '0;
        end else begin
            if (seq_err_inc_w && seq_err_q != 16'hFFFF) seq_err_d = seq_err_q + 16'd1;
            if (chk_err_inc_w && chk_err_q != 16'hFFFF) chk_err_d = chk_err_q + 16'd1;
            if (lose_lock_w && lost_lock_q != 16'hFFFF) lost_lock_d = lost_lock_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seq_err_q   <= '0;
            chk_err_q   <= '0;
            lost_lock_q <= '0;
        end else begin
            seq_err_q   <= seq_err_d;
            chk_err_q   <= chk_err_d;
            lost_lock_q <= lost_lock_d;
        end
    end

    assign seq_err_cnt_ob16   = seq_err_q;
    assign chk_err_cnt_ob16   = chk_err_q;
    assign lost_lock_cnt_ob16 = lost_lock_q;
`else
    logic unused_stats_w;
    assign unused_stats_w     = clear_stats_i | lose_lock_w;
    assign seq_err_cnt_ob16   = '0;
    assign chk_err_cnt_ob16   = '0;
    assign lost_lock_cnt_ob16 = '0;
`endif

endmodule

// File: tb/tb_gbt_rx_frame_checker.sv
// Randomized + directed bench for gbt_rx_frame_checker with a rule-level reference model and queue scoreboard.
module tb_gbt_rx_frame_checker;

    localparam int LOCK_GOOD      = 4;
    localparam int UNLOCK_BAD     = 3;
    localparam int TIMEOUT_CYCLES = 1024;
`ifdef GBT_RX_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int S_UNL = 0, S_SYN = 1, S_LCK = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [83:0] rx_data;
    logic        rx_isdata, rx_ready, clear_stats;
    logic [63:0] payload;
    logic [3:0]  frame_type;
    logic        payload_valid, locked;
    logic [15:0] seq_err_cnt, chk_err_cnt, lost_lock_cnt;

    always #5 clk = ~clk;

    gbt_rx_frame_checker #(
        .LOCK_GOOD(LOCK_GOOD), .UNLOCK_BAD(UNLOCK_BAD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .rx_data_ib84(rx_data), .rx_isdata_i(rx_isdata),
        .rx_ready_i(rx_ready), .clear_stats_i(clear_stats), .payload_ob64(payload),
        .frame_type_ob4(frame_type), .payload_valid_o(payload_valid), .locked_o(locked),
        .seq_err_cnt_ob16(seq_err_cnt), .chk_err_cnt_ob16(chk_err_cnt),
        .lost_lock_cnt_ob16(lost_lock_cnt)
    );

    typedef struct packed { logic [3:0] ty; logic [63:0] pl; } data_t;
    typedef struct packed { logic vld; logic lk; logic [15:0] se; logic [15:0] ce; logic [15:0] ll; } stat_t;
    data_t data_q[$];
    stat_t stat_q[$];

    int errors = 0;
    int checks = 0;

    int m_state, m_exp, m_good, m_bad, m_idle, m_se, m_ce, m_ll;
    int tx_seq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xor_bytes(input logic [63:0] p);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) r = r ^ p[8*i +: 8];
        return r;
    endfunction

    function automatic logic [83:0] mk(input int seq, input logic [63:0] pl, input bit bad_chk);
        logic [7:0] s = 8'(seq);
        logic [3:0] ty = 4'($urandom_range(0, 15));
        logic [7:0] c = xor_bytes(pl) ^ (bad_chk ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
        return {s, ty, c, pl};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic int sat(input int v, input bit inc, input bit clr);
        if (clr) return 0;
        if (inc && v < 65535) return v + 1;
        return v;
    endfunction

    task automatic model_reset();
        m_state = S_UNL; m_exp = 0; m_good = 0; m_bad = 0; m_idle = 0;
        m_se = 0; m_ce = 0; m_ll = 0;
    endtask

    // Applies the frame rules to one cycle of input and queues what the DUT must show next cycle.
    task automatic model_step(input logic r, input logic d, input logic c, input logic [83:0] w);
        int    seq = int'(w[83:76]);
        bit    chk_ok = (w[71:64] == xor_bytes(w[63:0]));
        bit    seq_ok = (seq == m_exp);
        bit    good = chk_ok && seq_ok;
        bit    emit = 0, lost = 0, se_inc = 0, ce_inc = 0;
        stat_t s;
        data_t dd;
        if (!r) begin
            lost = (m_state == S_LCK);
            m_state = S_UNL; m_good = 0; m_bad = 0; m_idle = 0;
        end else if (d) begin
            ce_inc = !chk_ok;
            se_inc = chk_ok && !seq_ok && (m_state != S_UNL);
            m_idle = 0;
            if (m_state == S_UNL) begin
                if (chk_ok) begin
                    m_good = 1; m_bad = 0;
                    if (m_good >= LOCK_GOOD) begin m_state = S_LCK; emit = 1; end
                    else m_state = S_SYN;
                end
            end else if (m_state == S_SYN) begin
                if (good) begin
                    m_good++;
                    if (m_good >= LOCK_GOOD) begin m_state = S_LCK; m_bad = 0; emit = 1; end
                end else begin
                    m_state = S_UNL; m_good = 0;
                end
            end else begin
                if (good) begin
                    m_bad = 0; emit = 1;
                end else begin
                    m_bad++;
                    if (m_bad >= UNLOCK_BAD) begin m_state = S_UNL; m_bad = 0; m_good = 0; lost = 1; end
                end
            end
            m_exp = chk_ok ? (seq + 1) % 256 : (m_exp + 1) % 256;
        end else if (m_state == S_LCK) begin
            m_idle++;
            if (m_idle >= TIMEOUT_CYCLES) begin m_state = S_UNL; m_idle = 0; m_good = 0; m_bad = 0; lost = 1; end
        end
        m_se = sat(m_se, se_inc, c);
        m_ce = sat(m_ce, ce_inc, c);
        m_ll = sat(m_ll, lost, c);
        s.vld = emit;
        s.lk  = (m_state == S_LCK);
        s.se  = STATS ? 16'(m_se) : 16'h0;
        s.ce  = STATS ? 16'(m_ce) : 16'h0;
        s.ll  = STATS ? 16'(m_ll) : 16'h0;
        stat_q.push_back(s);
        if (emit) begin
            dd.ty = w[75:72]; dd.pl = w[63:0];
            data_q.push_back(dd);
        end
    endtask

    task automatic step_now(input logic r, input logic d, input logic c, input logic [83:0] w);
        rx_ready = r; rx_isdata = d; clear_stats = c; rx_data = w;
        model_step(r, d, c, w);
    endtask

    task automatic drive(input logic r, input logic d, input logic c, input logic [83:0] w);
        @(negedge clk);
        step_now(r, d, c, w);
    endtask

    task automatic send(input int seq, input bit bad_chk);
        drive(1'b1, 1'b1, 1'b0, mk(seq, rnd64(), bad_chk));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, {$urandom(), rnd64()} );
    endtask

    task automatic drain();
        @(posedge clk); #2;
    endtask

    // Monitor: compares registered outputs one cycle after each modelled input.
    initial begin
        stat_t s;
        data_t d;
        forever begin
            @(posedge clk); #1;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("payload_valid", 64'(payload_valid), 64'(s.vld));
                check("locked", 64'(locked), 64'(s.lk));
                check("seq_err_cnt", 64'(seq_err_cnt), 64'(s.se));
                check("chk_err_cnt", 64'(chk_err_cnt), 64'(s.ce));
                check("lost_lock_cnt", 64'(lost_lock_cnt), 64'(s.ll));
            end
            if (payload_valid) begin
                if (data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got payload %h expected no strobe at %0t", payload, $time);
                end else begin
                    d = data_q.pop_front();
                    check("payload", payload, d.pl);
                    check("frame_type", 64'(frame_type), 64'(d.ty));
                end
            end
        end
    end

    initial begin
        bit r, dd, c, bad, skip;
        rst_n = 1'b0; rx_data = '0; rx_isdata = 1'b0; rx_ready = 1'b0; clear_stats = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_payload", payload, 64'h0);
        check("rst_type", 64'(frame_type), 64'h0);
        check("rst_valid", 64'(payload_valid), 64'h0);
        check("rst_locked", 64'(locked), 64'h0);
        check("rst_seq_err", 64'(seq_err_cnt), 64'h0);
        check("rst_chk_err", 64'(chk_err_cnt), 64'h0);
        check("rst_lost", 64'(lost_lock_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step_now(1'b1, 1'b0, 1'b0, '0);

        // Lock on seq 0..9; lock completes on seq 3.
        for (int i = 0; i < 10; i++) send(i, 1'b0);
        drain();
        check("locked_after_10", 64'(locked), 64'h1);
        // Three corrupted checksums drop lock, then relock.
        for (int i = 10; i < 13; i++) send(i, 1'b1);
        drain();
        check("unlocked_after_3_bad", 64'(locked), 64'h0);
        for (int i = 13; i < 20; i++) send(i, 1'b0);
        // Sequence skip while locked: 19 -> 21 -> 22.
        send(21, 1'b0);
        for (int i = 22; i < 26; i++) send(i, 1'b0);
        drain();
        check("lock_held_after_skip", 64'(locked), 64'h1);
        // Link drop, then wrap-around lock.
        drive(1'b0, 1'b1, 1'b0, mk(26, rnd64(), 1'b0));
        for (int i = 254; i < 260; i++) send(i % 256, 1'b0);
        // Idle timeout boundaries.
        idle(TIMEOUT_CYCLES - 1);
        send(4, 1'b0);
        drain();
        check("lock_held_1023_idle", 64'(locked), 64'h1);
        idle(TIMEOUT_CYCLES);
        drain();
        check("unlock_1024_idle", 64'(locked), 64'h0);
        // Clear wins over a same-cycle checksum error.
        drive(1'b1, 1'b1, 1'b1, mk(5, rnd64(), 1'b1));
        for (int i = 6; i < 12; i++) send(i, 1'b0);

        tx_seq = 12;
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 39) != 0);
            dd   = ($urandom_range(0, 4) != 0);
            c    = ($urandom_range(0, 29) == 0);
            bad  = ($urandom_range(0, 9) == 0);
            skip = ($urandom_range(0, 12) == 0);
            if (dd) begin
                if (skip) tx_seq = tx_seq + 1;
                drive(r, 1'b1, c, mk(tx_seq % 256, rnd64(), bad));
                tx_seq = tx_seq + 1;
            end else begin
                drive(r, 1'b0, c, {$urandom(), rnd64()});
            end
        end

`ifdef GBT_RX_CHECKER_STATS_EN
        for (int n = 0; n < 65540; n++) send(n % 256, 1'b1);
        drain();
        check("chk_err_saturated", 64'(chk_err_cnt), 64'hFFFF);
`endif

        // Asynchronous reset while locked and mid-frame.
        for (int i = 0; i < 6; i++) send(i, 1'b0);
        drive(1'b1, 1'b1, 1'b0, mk(6, rnd64(), 1'b0));
        drain();
        check("pre_async_rst_locked", 64'(locked), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_locked", 64'(locked), 64'h0);
        check("async_rst_payload", payload, 64'h0);
        check("async_rst_type", 64'(frame_type), 64'h0);
        check("async_rst_chk_err", 64'(chk_err_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step_now(1'b1, 1'b1, 1'b0, mk(40, rnd64(), 1'b0));
        for (int i = 41; i < 46; i++) send(i, 1'b0);
        drain();
        drain();
        check("stat_q_empty", 64'(stat_q.size()), 64'h0);
        check("data_q_empty", 64'(data_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
